// File: rtl/mean_pkg.sv
// Shared definitions for the mean family of averagers: rounding modes,
// window-fill state encoding and the saturating negate used on results.
package mean_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } mean_state_e;

  // Negate a sign-extended value and clamp to the largest positive value
  // representable in 'width' bits; only the most negative input clamps.
  function automatic logic signed [63:0] sat_negate(input logic signed [63:0] value,
                                                     input int width);
    logic signed [63:0] max_pos;
    logic signed [63:0] neg;
    max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
    neg     = -value;
    if (neg > max_pos) begin
      return max_pos;
    end else begin
      return neg;
    end
  endfunction

endpackage

// File: rtl/mean_window_buf.sv
// Circular sample store for the sliding window. old_data_o shows the entry
// about to be overwritten, i.e. the oldest sample once the window is full.
module mean_window_buf
  import mean_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] old_data_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] PTR_LAST = LOG2_DEPTH'(DEPTH - 1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q;
  logic [LOG2_DEPTH-1:0] ptr_d;

  // Next write pointer: flush to zero, or advance with wrap on each write.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (wr_en_i) begin
      if (ptr_q == PTR_LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + LOG2_DEPTH'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Write pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Sample storage; stale contents are masked by the fill count upstream.
  always_ff @(posedge clock) begin
    if (wr_en_i && !clear_i) begin
      mem_q[ptr_q] <= wr_data_i;
    end
  end

  assign old_data_o = mem_q[ptr_q];

endmodule

// File: rtl/moving_mean.sv
// Sliding-window signed mean over the last 2**LOG2_DEPTH accepted samples,
// with optional result negation and truncate / round-half-up selection.
module moving_mean
  import mean_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3,
  parameter int ROUND      = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             sign,
  input  logic             ivalid,
  input  logic [WIDTH-1:0] din,
  output logic             ovalid,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int AW    = WIDTH + LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic signed [AW-1:0] RND =
    (ROUND == ROUND_HALF_UP) ? AW'(DEPTH / 2) : AW'(0);

  logic                    accept_s;
  logic [WIDTH-1:0]        old_s;
  logic signed [AW-1:0]    din_ext_s;
  logic signed [AW-1:0]    old_ext_s;
  logic signed [WIDTH-1:0] res_s;
  logic [WIDTH-1:0]        res_neg_s;

  mean_state_e          state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 ovalid_q, ovalid_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 full_q, full_d;

  // A clear in the same cycle drops the sample.
  assign accept_s = ivalid & ~clear;

  mean_window_buf #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear),
    .wr_en_i    (accept_s),
    .wr_data_i  (din),
    .old_data_o (old_s)
  );

  // Window-fill state machine: count samples until the window is complete.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = ST_FILL;
      count_d = '0;
    end else if (accept_s) begin
      case (state_q)
        ST_FILL: begin
          count_d = count_q + CW'(1);
          if (count_q == CNT_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
          count_d = count_q;
        end
        default: begin
          state_d = ST_FILL;
          count_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      count_d = count_q;
    end
    full_d = (state_d == ST_RUN);
  end

  // Running sum: add the new sample, retire the oldest once the window is full.
  always_comb begin
    din_ext_s = {{LOG2_DEPTH{din[WIDTH-1]}}, din};
    if (state_q == ST_RUN) begin
      old_ext_s = {{LOG2_DEPTH{old_s[WIDTH-1]}}, old_s};
    end else begin
      old_ext_s = '0;
    end
    acc_d      = acc_q;
    s1_valid_d = 1'b0;
    s1_sign_d  = s1_sign_q;
    if (clear) begin
      acc_d      = '0;
      s1_valid_d = 1'b0;
      s1_sign_d  = 1'b0;
    end else if (accept_s) begin
      acc_d      = acc_q + din_ext_s - old_ext_s;
      s1_valid_d = (state_q == ST_RUN) || (count_q == CNT_LAST);
      s1_sign_d  = sign;
    end else begin
      acc_d      = acc_q;
      s1_valid_d = 1'b0;
      s1_sign_d  = s1_sign_q;
    end
  end

  // Output stage: scale the sum, optionally negate, and suppress on clear.
  always_comb begin
    res_s     = WIDTH'((acc_q + RND) >>> LOG2_DEPTH);
    res_neg_s = WIDTH'(sat_negate(64'(res_s), WIDTH));
    ovalid_d  = s1_valid_q & ~clear;
    dout_d    = dout_q;
    if (s1_valid_q && !clear) begin
      if (s1_sign_q) begin
        dout_d = res_neg_s;
      end else begin
        dout_d = res_s;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // State, accumulator and pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      count_q    <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      ovalid_q   <= 1'b0;
      dout_q     <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      ovalid_q   <= ovalid_d;
      dout_q     <= dout_d;
      full_q     <= full_d;
    end
  end

  assign ovalid = ovalid_q;
  assign dout   = dout_q;
  assign full   = full_q;

endmodule
